// File: rtl/bp_pht_port_arbiter_if.sv
// rtl/bp_pht_port_arbiter_if.sv - fetch/resolve/PHT-port bundle for the PHT port arbiter.
interface bp_pht_port_arbiter_if #(
  parameter int IDX_W = 10
) ();
  logic             lookup_v_i;
  logic [IDX_W-1:0] lookup_idx_i;
  logic             lookup_ready_o;
  logic             pred_v_o;
  logic [1:0]       pred_ctr_o;
  logic             pred_taken_o;
  logic             upd_v_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_taken_i;
  logic             upd_ready_o;
  logic             pht_v_o;
  logic             pht_w_o;
  logic [IDX_W-1:0] pht_idx_o;
  logic [1:0]       pht_wdata_o;
  logic [1:0]       pht_rdata_i;
  logic             init_done_o;

  modport slave (
    input  lookup_v_i, lookup_idx_i, upd_v_i, upd_idx_i, upd_taken_i, pht_rdata_i,
    output lookup_ready_o, pred_v_o, pred_ctr_o, pred_taken_o, upd_ready_o,
           pht_v_o, pht_w_o, pht_idx_o, pht_wdata_o, init_done_o
  );

  modport master (
    output lookup_v_i, lookup_idx_i, upd_v_i, upd_idx_i, upd_taken_i, pht_rdata_i,
    input  lookup_ready_o, pred_v_o, pred_ctr_o, pred_taken_o, upd_ready_o,
           pht_v_o, pht_w_o, pht_idx_o, pht_wdata_o, init_done_o
  );
endinterface

// File: rtl/bp_pht_port_arbiter.sv
// rtl/bp_pht_port_arbiter.sv - single-port PHT sequencer: init sweep, lookups, queued RMW updates.
// Optional perf counters enabled by defining BP_PHT_ARB_PERF_EN.
module bp_pht_port_arbiter #(
  parameter int         IDX_W          = 10,
  parameter int         UPD_FIFO_DEPTH = 4,
  parameter int         STARVE_LIMIT   = 8,
  parameter logic [1:0] INIT_CTR       = 2'b01
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_pht_port_arbiter_if.slave   bus,
  output logic [31:0]            perf_lookup_stall_o,
  output logic [31:0]            perf_upd_full_o,
  output logic [31:0]            perf_forced_o
);
  localparam int AW = $clog2(UPD_FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {S_INIT, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx;
  logic             r_init_done;
  logic             r_wb_pend;
  logic [IDX_W-1:0] r_wb_idx;
  logic             r_wb_taken;
  logic             r_pred_v;
  logic [SW-1:0]    r_starve;
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [IDX_W-1:0] r_fifo_idx [UPD_FIFO_DEPTH];
  logic             r_fifo_tkn [UPD_FIFO_DEPTH];

  logic             w_run, w_empty, w_full, w_push, w_forced;
  logic             w_lookup_ready, w_lookup_grant, w_upd_read;
  logic             w_pht_v, w_pht_w;
  logic [IDX_W-1:0] w_pht_idx;
  logic [1:0]       w_pht_wdata;
  logic             w_sweep_last;
  logic [1:0]       w_pred_ctr;

  function automatic logic [1:0] f_sat(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Outputs are forced low while reset is held, not just from the next edge.
  assign w_run        = !reset_i && (r_state == S_RUN);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push       = bus.upd_v_i && bus.upd_ready_o;
  assign w_forced     = w_run && !r_wb_pend && !w_empty && (r_starve == SW'(STARVE_LIMIT));
  assign w_sweep_last = (r_sweep_idx == {IDX_W{1'b1}});

  always_comb begin
    w_state_nxt    = r_state;
    w_pht_v        = 1'b0;
    w_pht_w        = 1'b0;
    w_pht_idx      = '0;
    w_pht_wdata    = '0;
    w_lookup_ready = 1'b0;
    w_lookup_grant = 1'b0;
    w_upd_read     = 1'b0;
    if (!reset_i) begin
      case (r_state)
        S_INIT: begin
          w_pht_v     = 1'b1;
          w_pht_w     = 1'b1;
          w_pht_idx   = r_sweep_idx;
          w_pht_wdata = INIT_CTR;
          if (w_sweep_last) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (r_wb_pend) begin
            w_pht_v     = 1'b1;
            w_pht_w     = 1'b1;
            w_pht_idx   = r_wb_idx;
            w_pht_wdata = f_sat(bus.pht_rdata_i, r_wb_taken);
          end else if (w_forced) begin
            w_pht_v    = 1'b1;
            w_pht_idx  = r_fifo_idx[r_rd_ptr[AW-1:0]];
            w_upd_read = 1'b1;
          end else begin
            w_lookup_ready = 1'b1;
            if (bus.lookup_v_i) begin
              w_pht_v        = 1'b1;
              w_pht_idx      = bus.lookup_idx_i;
              w_lookup_grant = 1'b1;
            end else if (!w_empty) begin
              w_pht_v    = 1'b1;
              w_pht_idx  = r_fifo_idx[r_rd_ptr[AW-1:0]];
              w_upd_read = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_INIT;
      r_sweep_idx <= '0;
      r_init_done <= 1'b0;
      r_wb_pend   <= 1'b0;
      r_wb_idx    <= '0;
      r_wb_taken  <= 1'b0;
      r_pred_v    <= 1'b0;
      r_starve    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_sweep_idx <= r_sweep_idx + IDX_W'(1);
        if (w_sweep_last) r_init_done <= 1'b1;
      end
      r_wb_pend <= w_upd_read;
      if (w_upd_read) begin
        r_wb_idx   <= r_fifo_idx[r_rd_ptr[AW-1:0]];
        r_wb_taken <= r_fifo_tkn[r_rd_ptr[AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      r_pred_v <= w_lookup_grant;
      if (w_empty || w_upd_read)
        r_starve <= '0;
      else if (w_lookup_grant && (r_starve != SW'(STARVE_LIMIT)))
        r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr[AW-1:0]] <= bus.upd_idx_i;
      r_fifo_tkn[r_wr_ptr[AW-1:0]] <= bus.upd_taken_i;
    end
  end

  assign w_pred_ctr         = r_pred_v ? bus.pht_rdata_i : 2'b00;
  assign bus.pred_v_o       = r_pred_v;
  assign bus.pred_ctr_o     = w_pred_ctr;
  assign bus.pred_taken_o   = w_pred_ctr[1];
  assign bus.lookup_ready_o = w_lookup_ready;
  assign bus.upd_ready_o    = w_run && !w_full;
  assign bus.pht_v_o        = w_pht_v;
  assign bus.pht_w_o        = w_pht_w;
  assign bus.pht_idx_o      = w_pht_idx;
  assign bus.pht_wdata_o    = w_pht_wdata;
  assign bus.init_done_o    = r_init_done;

`ifdef BP_PHT_ARB_PERF_EN
  logic [31:0] r_perf_stall, r_perf_full, r_perf_forced;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perf_stall  <= '0;
      r_perf_full   <= '0;
      r_perf_forced <= '0;
    end else begin
      if (w_run && bus.lookup_v_i && !w_lookup_ready) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_run && bus.upd_v_i && w_full)             r_perf_full  <= r_perf_full + 32'd1;
      if (w_forced)                                   r_perf_forced <= r_perf_forced + 32'd1;
    end
  end

  assign perf_lookup_stall_o = r_perf_stall;
  assign perf_upd_full_o     = r_perf_full;
  assign perf_forced_o       = r_perf_forced;
`else
  assign perf_lookup_stall_o = '0;
  assign perf_upd_full_o     = '0;
  assign perf_forced_o       = '0;
`endif
endmodule

// File: tb/tb_bp_pht_port_arbiter.sv
// tb/tb_bp_pht_port_arbiter.sv - directed scoreboard bench for bp_pht_port_arbiter.
module tb_bp_pht_port_arbiter;
  localparam int IDX_W = 3;
  localparam int N     = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_pht_port_arbiter_if #(.IDX_W(IDX_W)) bus ();
  logic [31:0] perf_stall, perf_full, perf_forced;

  bp_pht_port_arbiter #(
    .IDX_W(IDX_W), .UPD_FIFO_DEPTH(4), .STARVE_LIMIT(8), .INIT_CTR(2'b01)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus),
    .perf_lookup_stall_o(perf_stall), .perf_upd_full_o(perf_full), .perf_forced_o(perf_forced)
  );

  // PHT SRAM: 1-cycle read latency, writes visible to the next cycle's read
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (bus.pht_v_o) begin
      if (bus.pht_w_o) mem[bus.pht_idx_o] <= bus.pht_wdata_o;
      else             bus.pht_rdata_i    <= mem[bus.pht_idx_o];
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  bit run_mode = 1'b0;
  bit last_up_acc;
  logic [1:0]       ref_ctr [N];
  logic [1:0]       pred_q [$];
  logic [IDX_W+1:0] wr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] c, input logic taken);
    int v;
    v = int'(c) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  task automatic sample();
    logic [1:0]       e;
    logic [IDX_W+1:0] w;
    logic [1:0]       n;
    @(negedge clk);
    if (bus.pred_v_o === 1'b1) begin
      n_checks++;
      assert (pred_q.size() > 0) else begin
        n_err++;
        $error("FAIL pred_unexpected observed=pred_v_o=1 expected=no prediction");
      end
      if (pred_q.size() > 0) begin
        e = pred_q.pop_front();
        chk("pred_ctr", 32'(bus.pred_ctr_o), 32'(e));
        chk("pred_taken", 32'(bus.pred_taken_o), 32'(e[1]));
      end
    end
    if (run_mode && bus.pht_v_o === 1'b1 && bus.pht_w_o === 1'b1) begin
      n_checks++;
      assert (wr_q.size() > 0) else begin
        n_err++;
        $error("FAIL wb_unexpected observed=write idx %0d expected=no write", bus.pht_idx_o);
      end
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        chk("wb_idx", 32'(bus.pht_idx_o), 32'(w[IDX_W+1:2]));
        chk("wb_data", 32'(bus.pht_wdata_o), 32'(w[1:0]));
      end
    end
    if (bus.lookup_v_i && bus.lookup_ready_o === 1'b1)
      pred_q.push_back(ref_ctr[bus.lookup_idx_i]);
    last_up_acc = bus.upd_v_i && (bus.upd_ready_o === 1'b1);
    if (last_up_acc) begin
      n = model_next(ref_ctr[bus.upd_idx_i], bus.upd_taken_i);
      ref_ctr[bus.upd_idx_i] = n;
      wr_q.push_back({bus.upd_idx_i, n});
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic init_sweep();
    for (int i = 0; i < N; i++) begin
      sample();
      chk("init_v", 32'(bus.pht_v_o), 1);
      chk("init_w", 32'(bus.pht_w_o), 1);
      chk("init_idx", 32'(bus.pht_idx_o), 32'(i));
      chk("init_wdata", 32'(bus.pht_wdata_o), 1);
      chk("init_lk_ready", 32'(bus.lookup_ready_o), 0);
      chk("init_upd_ready", 32'(bus.upd_ready_o), 0);
      chk("init_done_early", 32'(bus.init_done_o), 0);
      advance();
    end
    bus.lookup_v_i = 1'b0;
    bus.upd_v_i    = 1'b0;
    for (int i = 0; i < N; i++) ref_ctr[i] = 2'b01;
    run_mode = 1'b1;
    sample();
    chk("init_done", 32'(bus.init_done_o), 1);
    chk("run_idle_v", 32'(bus.pht_v_o), 0);
    chk("run_lk_ready", 32'(bus.lookup_ready_o), 1);
    chk("run_upd_ready", 32'(bus.upd_ready_o), 1);
    advance();
  endtask

  task automatic drain(input string tag);
    bus.lookup_v_i = 1'b0;
    bus.upd_v_i    = 1'b0;
    for (int i = 0; i < 40 && (wr_q.size() > 0 || pred_q.size() > 0); i++) cyc();
    cyc();
    chk({tag, "_wr_left"}, 32'(wr_q.size()), 0);
    chk({tag, "_pred_left"}, 32'(pred_q.size()), 0);
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx);
    bus.lookup_v_i   = 1'b1;
    bus.lookup_idx_i = idx;
    sample();
    chk("lk_read_v", 32'(bus.pht_v_o), 1);
    chk("lk_read_w", 32'(bus.pht_w_o), 0);
    chk("lk_read_idx", 32'(bus.pht_idx_o), 32'(idx));
    advance();
    bus.lookup_v_i = 1'b0;
    sample();
    chk("lk_pred_v", 32'(bus.pred_v_o), 1);
    advance();
  endtask

  logic [IDX_W-1:0] t5_idx [5];
  logic             t5_tkn [5];

  initial begin
    rst = 1'b1;
    bus.lookup_v_i   = 1'b1;
    bus.lookup_idx_i = 3'd4;
    bus.upd_v_i      = 1'b1;
    bus.upd_idx_i    = '0;
    bus.upd_taken_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("rst_pht_v", 32'(bus.pht_v_o), 0);
    chk("rst_lk_ready", 32'(bus.lookup_ready_o), 0);
    chk("rst_upd_ready", 32'(bus.upd_ready_o), 0);
    chk("rst_pred_v", 32'(bus.pred_v_o), 0);
    chk("rst_init_done", 32'(bus.init_done_o), 0);
    advance();
    rst = 1'b0;
    init_sweep();

    // single lookup after init
    lookup(3'd5);
    drain("t2");

    // three taken updates to idx 2 then lookup
    bus.upd_v_i = 1'b1; bus.upd_idx_i = 3'd2; bus.upd_taken_i = 1'b1;
    repeat (3) begin
      sample();
      chk("t3_upd_acc", 32'(last_up_acc), 1);
      advance();
    end
    drain("t3");
    lookup(3'd2);
    drain("t3b");

    // starvation: one queued update against continuous lookups
    bus.lookup_v_i = 1'b1; bus.lookup_idx_i = 3'd1;
    bus.upd_v_i = 1'b1; bus.upd_idx_i = 3'd6; bus.upd_taken_i = 1'b0;
    sample();
    chk("t4_upd_acc", 32'(last_up_acc), 1);
    chk("t4_c0_ready", 32'(bus.lookup_ready_o), 1);
    advance();
    bus.upd_v_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      sample();
      chk("t4_grant", 32'(bus.lookup_ready_o), 1);
      advance();
    end
    sample();
    chk("t4_forced_ready", 32'(bus.lookup_ready_o), 0);
    chk("t4_forced_w", 32'(bus.pht_w_o), 0);
    chk("t4_forced_idx", 32'(bus.pht_idx_o), 6);
    advance();
    sample();
    chk("t4_wb_ready", 32'(bus.lookup_ready_o), 0);
    chk("t4_wb_w", 32'(bus.pht_w_o), 1);
    advance();
    sample();
    chk("t4_resume", 32'(bus.lookup_ready_o), 1);
    advance();
    drain("t4");

    // FIFO full while lookups hog the port
    t5_idx[0] = 3'd3; t5_tkn[0] = 1'b1;
    t5_idx[1] = 3'd4; t5_tkn[1] = 1'b1;
    t5_idx[2] = 3'd3; t5_tkn[2] = 1'b1;
    t5_idx[3] = 3'd7; t5_tkn[3] = 1'b0;
    t5_idx[4] = 3'd0; t5_tkn[4] = 1'b1;
    begin
      int k;
      k = 0;
      bus.lookup_v_i = 1'b1; bus.lookup_idx_i = 3'd5;
      bus.upd_v_i = 1'b1; bus.upd_idx_i = t5_idx[0]; bus.upd_taken_i = t5_tkn[0];
      for (int c = 0; c <= 10; c++) begin
        sample();
        chk($sformatf("t5_upd_ready_c%0d", c), 32'(bus.upd_ready_o), (c < 4 || c == 10) ? 1 : 0);
        if (last_up_acc) k++;
        advance();
        if (k >= 5) bus.upd_v_i = 1'b0;
        else begin
          bus.upd_idx_i   = t5_idx[k];
          bus.upd_taken_i = t5_tkn[k];
        end
      end
      chk("t5_accepted", 32'(k), 5);
    end
    drain("t5");

`ifdef BP_PHT_ARB_PERF_EN
    chk("perf_stall", perf_stall, 4);
    chk("perf_full", perf_full, 6);
    chk("perf_forced", perf_forced, 2);
`else
    chk("perf_stall_tied", perf_stall, 0);
    chk("perf_full_tied", perf_full, 0);
    chk("perf_forced_tied", perf_forced, 0);
`endif

    // reset with queued updates and a lookup in flight
    bus.lookup_v_i = 1'b1; bus.lookup_idx_i = 3'd1;
    bus.upd_v_i = 1'b1; bus.upd_taken_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.upd_idx_i = IDX_W'(c + 2);
      sample();
      chk("t6_upd_acc", 32'(last_up_acc), 1);
      advance();
    end
    rst = 1'b1;
    pred_q.delete();
    wr_q.delete();
    run_mode = 1'b0;
    sample();
    chk("t6_pred_v", 32'(bus.pred_v_o), 0);
    chk("t6_pred_ctr", 32'(bus.pred_ctr_o), 0);
    chk("t6_pht_v", 32'(bus.pht_v_o), 0);
    chk("t6_lk_ready", 32'(bus.lookup_ready_o), 0);
    chk("t6_upd_ready", 32'(bus.upd_ready_o), 0);
    chk("t6_init_done", 32'(bus.init_done_o), 0);
    advance();
    cyc();
    rst = 1'b0;
    init_sweep();
    lookup(3'd2);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
